// File: rtl/gcd_lcm_sequencer.sv
// gcd_lcm_sequencer
//   Front-end for the serial GCD/LCM engine. It takes an operand pair on a
//   valid/ready handshake and handles zero operands itself. Non-zero pairs go
//   to the engine as a start pulse carrying A, then B on the next cycle. The
//   block then waits for done (or a timeout) and holds the result on a
//   valid/ready output port. It owns the engine's active-low reset, which is
//   released only while a job is being loaded or run.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake, in_a / in_b operands
//   out_valid/out_ready   : result handshake, out_gcd / out_lcm / out_err
//   eng_rst_n, eng_start  : engine reset (active low) and start pulse
//   eng_data              : engine serial operand bus (A, then B)
//   eng_done, eng_gcd/lcm : engine completion and results
module gcd_lcm_sequencer #(
  parameter int SIZE    = 8,
  parameter int TIMEOUT = 300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_a,
  input  logic [SIZE-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIZE-1:0]   out_gcd,
  output logic [2*SIZE:0]   out_lcm,
  output logic              out_err,
  output logic              eng_rst_n,
  output logic              eng_start,
  output logic [SIZE-1:0]   eng_data,
  input  logic              eng_done,
  input  logic [SIZE-1:0]   eng_gcd,
  input  logic [2*SIZE:0]   eng_lcm
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT, S_RESULT
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [SIZE-1:0]   out_gcd_q, out_gcd_d;
  logic [2*SIZE:0]   out_lcm_q, out_lcm_d;
  logic              out_err_q, out_err_d;
  logic              eng_rst_n_q, eng_rst_n_d;
  logic              eng_start_q, eng_start_d;
  logic [SIZE-1:0]   eng_data_q, eng_data_d;
  logic [SIZE-1:0]   b_q, b_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Outputs are computed alongside the next state so that, once registered,
  // they line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_gcd_d   = out_gcd_q;
    out_lcm_d   = out_lcm_q;
    out_err_d   = out_err_q;
    eng_rst_n_d = eng_rst_n_q;
    eng_start_d = eng_start_q;
    eng_data_d  = eng_data_q;
    b_d         = b_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          if (in_a == '0 || in_b == '0) begin
            // With at least one operand zero, OR yields the non-zero operand
            // (or 0 when both are zero). The engine is never touched.
            state_d     = S_RESULT;
            out_valid_d = 1'b1;
            out_gcd_d   = in_a | in_b;
            out_lcm_d   = '0;
            out_err_d   = 1'b0;
          end else begin
            state_d     = S_LOAD_A;
            eng_rst_n_d = 1'b1;
            eng_start_d = 1'b1;
            eng_data_d  = in_a;
            b_d         = in_b;
          end
        end
      end

      S_LOAD_A: begin
        state_d     = S_LOAD_B;
        eng_start_d = 1'b0;
        eng_data_d  = b_q;
        cnt_d       = '0;
      end

      S_LOAD_B: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end

      S_WAIT: begin
        // Done wins over a simultaneous timeout.
        if (eng_done) begin
          state_d     = S_RESULT;
          out_valid_d = 1'b1;
          out_gcd_d   = eng_gcd;
          out_lcm_d   = eng_lcm;
          out_err_d   = 1'b0;
          eng_rst_n_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_RESULT;
          out_valid_d = 1'b1;
          out_gcd_d   = '0;
          out_lcm_d   = '0;
          out_err_d   = 1'b1;
          eng_rst_n_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESULT: begin
        // Result fields are left untouched here, so they stay stable while
        // the consumer stalls.
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        eng_rst_n_d = 1'b0;
        eng_start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_gcd_q   <= '0;
      out_lcm_q   <= '0;
      out_err_q   <= 1'b0;
      eng_rst_n_q <= 1'b0;
      eng_start_q <= 1'b0;
      eng_data_q  <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_gcd_q   <= out_gcd_d;
      out_lcm_q   <= out_lcm_d;
      out_err_q   <= out_err_d;
      eng_rst_n_q <= eng_rst_n_d;
      eng_start_q <= eng_start_d;
      eng_data_q  <= eng_data_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_gcd   = out_gcd_q;
  assign out_lcm   = out_lcm_q;
  assign out_err   = out_err_q;
  assign eng_rst_n = eng_rst_n_q;
  assign eng_start = eng_start_q;
  assign eng_data  = eng_data_q;

endmodule

// File: tb/tb_gcd_lcm_sequencer.sv
// Testbench for gcd_lcm_sequencer: a behavioural engine model answers start
// pulses, and a reference model built from plain gcd/lcm arithmetic predicts
// every result.
module tb_gcd_lcm_sequencer;
  localparam int SIZE    = 8;
  localparam int TIMEOUT = 300;
  localparam int LW      = 2*SIZE+1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [SIZE-1:0] in_a, in_b;
  logic            out_valid, out_ready;
  logic [SIZE-1:0] out_gcd;
  logic [LW-1:0]   out_lcm;
  logic            out_err;
  logic            eng_rst_n, eng_start;
  logic [SIZE-1:0] eng_data;
  logic            eng_done = 1'b0;
  logic [SIZE-1:0] eng_gcd  = '0;
  logic [LW-1:0]   eng_lcm  = '0;

  int errors = 0;
  int checks = 0;

  gcd_lcm_sequencer #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_gcd(out_gcd), .out_lcm(out_lcm), .out_err(out_err),
    .eng_rst_n(eng_rst_n), .eng_start(eng_start), .eng_data(eng_data),
    .eng_done(eng_done), .eng_gcd(eng_gcd), .eng_lcm(eng_lcm)
  );

  always #5 clk = ~clk;

  function automatic int ref_gcd(input int a, input int b);
    int x = a, y = b, t;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  // Engine model: takes A with start, B the next cycle, answers after a
  // configurable latency (or never, when stalled), and stays done until reset.
  int              eng_ph  = 0;
  int              lat_cnt = 0;
  int              lat_cfg = 0;
  bit              stall   = 0;
  logic [SIZE-1:0] ea = '0, eb = '0;
  int              start_cnt = 0;

  always @(posedge clk) begin
    if (eng_start === 1'b1) start_cnt++;
    if (eng_rst_n !== 1'b1) begin
      eng_ph <= 0; eng_done <= 1'b0; eng_gcd <= '0; eng_lcm <= '0;
    end else begin
      case (eng_ph)
        0: if (eng_start === 1'b1) begin ea <= eng_data; eng_ph <= 1; end
        1: begin eb <= eng_data; lat_cnt <= lat_cfg; eng_ph <= 2; end
        2: if (!stall) begin
             if (lat_cnt == 0) begin
               eng_done <= 1'b1;
               eng_gcd  <= SIZE'(ref_gcd(int'(ea), int'(eb)));
               eng_lcm  <= LW'((int'(ea) * int'(eb)) / ref_gcd(int'(ea), int'(eb)));
               eng_ph   <= 3;
             end else lat_cnt <= lat_cnt - 1;
           end
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input int a, input int b, input bit stl, input int lat,
                         input int hold, input bit exp_to);
    int g, l, n, s0;
    bit e, zero, prev_done;
    zero = (a == 0) || (b == 0);
    e = 0; l = 0;
    if (a == 0 && b == 0)      g = 0;
    else if (a == 0)           g = b;
    else if (b == 0)           g = a;
    else if (exp_to) begin     g = 0; e = 1; end
    else begin                 g = ref_gcd(a, b); l = a * b / g; end

    stall = stl; lat_cfg = lat; out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_idle", longint'(in_ready), 1);
    s0 = start_cnt;
    in_valid = 1'b1; in_a = SIZE'(a); in_b = SIZE'(b);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_a = SIZE'($urandom); in_b = SIZE'($urandom);

    if (zero) begin
      chk("zero_bypass_latency", longint'(out_valid), 1);
    end else begin
      chk("load_a", longint'({in_ready, eng_rst_n, eng_start, eng_data}),
          longint'({1'b0, 1'b1, 1'b1, SIZE'(a)}));
      @(negedge clk);
      chk("load_b", longint'({eng_rst_n, eng_start, eng_data}),
          longint'({1'b1, 1'b0, SIZE'(b)}));
      n = 1; prev_done = 0;
      while (out_valid !== 1'b1 && n < TIMEOUT + 20) begin
        prev_done = eng_done;
        @(negedge clk);
        n++;
      end
      chk("out_valid_seen", longint'(out_valid), 1);
      if (exp_to) chk("timeout_latency", longint'(n), longint'(TIMEOUT + 2));
      else begin
        chk("done_latency", longint'(prev_done), 1);
        chk("engine_operands", longint'({ea, eb}), longint'({SIZE'(a), SIZE'(b)}));
      end
    end
    chk("start_pulses", longint'(start_cnt - s0), zero ? 0 : 1);

    chk("result", longint'({out_valid, in_ready, out_gcd, out_lcm, out_err}),
        longint'({1'b1, 1'b0, SIZE'(g), LW'(l), e}));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("result_held", longint'({out_valid, in_ready, out_gcd, out_lcm, out_err}),
          longint'({1'b1, 1'b0, SIZE'(g), LW'(l), e}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_handshake", longint'({out_valid, in_ready, eng_rst_n, eng_start}),
        longint'(4'b0100));
  endtask

  initial begin
    bit vseen;
    int ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", longint'({in_ready, out_valid, out_err, eng_rst_n, eng_start}),
        longint'(5'b10000));
    chk("reset_data", longint'({out_gcd, out_lcm, eng_data}), 0);
    rst = 1'b0;

    run_job(12, 18, 0, 3, 0, 0);
    run_job(7, 7, 0, 0, 0, 0);
    run_job(9, 6, 0, 5, 0, 0);
    run_job(0, 9, 0, 0, 0, 0);
    run_job(0, 0, 0, 0, 1, 0);
    run_job(8, 12, 0, 2, 5, 0);
    run_job(255, 1, 1, 0, 0, 1);
    run_job(4, 6, 0, 1, 0, 0);

    // Reset pulsed while the engine is busy: job is dropped silently.
    stall = 1;
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'd200; in_b = 8'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_reset", longint'({out_valid, eng_rst_n, in_ready, eng_start}),
        longint'(4'b0010));
    vseen = 0;
    out_ready = 1'b1;
    repeat (8) begin @(negedge clk); vseen |= (out_valid === 1'b1); end
    out_ready = 1'b0;
    chk("no_partial_result", longint'(vseen), 0);
    run_job(10, 4, 0, 4, 0, 0);

    for (int k = 0; k < 20; k++) begin
      ra = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      run_job(ra, rb, 0, $urandom_range(0, 15), $urandom_range(0, 3), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
